log_ftu: RTL and testbench

//  FIFO-to-UART serializer; the transmit-side counterpart of the byte-to-FIFO packer.

---
 rtl/log_ftu_if.sv | 25 ++
 rtl/log_ftu.sv | 101 ++++++++++
 tb/tb_log_ftu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/log_ftu_if.sv
// FIFO-side and UART-side signals of the FIFO-to-UART serializer.
// The serializer connects as master; the FIFO/UART side connects as slave.
interface log_ftu_if #(
  parameter int unsigned DATA_FIFO = 64,
  parameter int unsigned DATA      = 8
) ();
  logic                 fifo_empty;
  logic [DATA_FIFO-1:0] fifo_dout;
  logic                 tx_busy;
  logic                 pop;
  logic                 tx_start;
  logic [DATA-1:0]      tx_data;
  logic                 active;
  logic [15:0]          word_cnt;

  modport master (
    input  fifo_empty, fifo_dout, tx_busy,
    output pop, tx_start, tx_data, active, word_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, tx_busy,
    input  pop, tx_start, tx_data, active, word_cnt
  );
endinterface

// File: rtl/log_ftu.sv
// FIFO-to-UART serializer: pops one wide FIFO word and hands its bytes,
// LSB byte first, to the UART transmitter one at a time.
module log_ftu #(
  parameter int unsigned DATA_FIFO = 64,
  parameter int unsigned DATA      = 8,
  parameter int unsigned NUM_BYTES = 8
) (
  input  logic      sys_clk,
  input  logic      sys_rst_l,
  log_ftu_if.master bus
);
  localparam int unsigned CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned WC_W  = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    LOAD      = 3'd2,
    READY     = 3'd3,
    START     = 3'd4,
    WAIT_BUSY = 3'd5,
    WAIT_DONE = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_FIFO-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [DATA-1:0]      tx_data_q, tx_data_d;
  logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
  logic                 pop_q, pop_d;
  logic                 tx_start_q, tx_start_d;
  logic                 active_q, active_d;

  // Next-state and datapath; strobes are registered from the next state.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    tx_data_d  = tx_data_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      IDLE:      if (!bus.fifo_empty) state_d = POP;
      POP:       state_d = LOAD;
      LOAD: begin
        shreg_d    = bus.fifo_dout;
        byte_cnt_d = '0;
        state_d    = READY;
      end
      READY: begin
        tx_data_d = shreg_q[DATA-1:0];
        if (!bus.tx_busy) state_d = START;
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (byte_cnt_q == CNT_W'(NUM_BYTES - 1)) begin
            word_cnt_d = word_cnt_q + WC_W'(1);
            state_d    = IDLE;
          end else begin
            shreg_d    = shreg_q >> DATA;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            state_d    = READY;
          end
        end
      end
      default:   state_d = IDLE;
    endcase
    pop_d      = (state_d == POP);
    tx_start_d = (state_d == START);
    active_d   = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      tx_data_q  <= '0;
      word_cnt_q <= '0;
      pop_q      <= 1'b0;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      tx_data_q  <= tx_data_d;
      word_cnt_q <= word_cnt_d;
      pop_q      <= pop_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.active   = active_q;
  assign bus.word_cnt = word_cnt_q;
endmodule

// File: tb/tb_log_ftu.sv
// Directed bench for log_ftu: small FIFO and UART models around the DUT,
// expected bytes and counts written out by hand.
module tb_log_ftu;
  localparam int unsigned BUSY_LEN = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_l = 1'b0;
  logic hold_busy = 1'b0;

  log_ftu_if #(.DATA_FIFO(64), .DATA(8)) ifc ();

  log_ftu #(.DATA_FIFO(64), .DATA(8), .NUM_BYTES(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .bus       (ifc.master)
  );

  always #5 sys_clk = ~sys_clk;

  // FIFO model: initial block pushes, model pops on the DUT strobe
  logic [63:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [63:0] fifo_dout_r = '0;
  assign ifc.fifo_empty = (wr_ptr == rd_ptr);
  assign ifc.fifo_dout  = fifo_dout_r;

  // UART model: busy for BUSY_LEN cycles after each tx_start
  int          busy_cnt = 0;
  assign ifc.tx_busy = (busy_cnt != 0) || hold_busy;

  logic [7:0]  cap [0:127];
  int          cap_n = 0;
  int          start_cnt = 0;
  int          pop_cnt = 0;
  int          active_cnt = 0;
  int          viol = 0;
  int          cyc = 0;
  int          wc_edge = 0;
  int          last_gap = 0;
  logic [15:0] wc_prev = '0;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (!sys_rst_l) busy_cnt <= 0;
    else if (ifc.tx_start) begin
      if (ifc.tx_busy) viol <= viol + 1;
      busy_cnt   <= BUSY_LEN;
      cap[cap_n[6:0]] <= ifc.tx_data;
      cap_n      <= cap_n + 1;
      start_cnt  <= start_cnt + 1;
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (ifc.pop) begin
      pop_cnt     <= pop_cnt + 1;
      fifo_dout_r <= mem[rd_ptr[3:0]];
      rd_ptr      <= rd_ptr + 1;
      last_gap    <= cyc - wc_edge;
    end
    if (ifc.word_cnt != wc_prev) wc_edge <= cyc;
    wc_prev <= ifc.word_cnt;
    if (ifc.active) active_cnt <= active_cnt + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    @(negedge sys_clk);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_wc(input logic [15:0] exp, input string tag);
    int n = 0;
    while (ifc.word_cnt !== exp && n < 3000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check(tag, 64'(ifc.word_cnt), 64'(exp));
  endtask

  int base, p0, s0, a0;

  initial begin
    // Reset
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_pop", 64'(ifc.pop), 64'h0);
    check("rst_tx_start", 64'(ifc.tx_start), 64'h0);
    check("rst_active", 64'(ifc.active), 64'h0);
    check("rst_tx_data", 64'(ifc.tx_data), 64'h0);
    check("rst_word_cnt", 64'(ifc.word_cnt), 64'h0);
    @(negedge sys_clk) sys_rst_l = 1'b1;

    // T2: empty FIFO, nothing moves
    p0 = pop_cnt; s0 = start_cnt; a0 = active_cnt;
    repeat (100) @(posedge sys_clk);
    #1;
    check("t2_pops", 64'(pop_cnt - p0), 64'h0);
    check("t2_starts", 64'(start_cnt - s0), 64'h0);
    check("t2_active", 64'(active_cnt - a0), 64'h0);

    // T1: one word, latency and byte order
    base = cap_n; p0 = pop_cnt; s0 = start_cnt;
    push(64'h8877665544332211);
    @(posedge sys_clk); #1;
    check("t1_pop_latency", 64'(ifc.pop), 64'h1);
    check("t1_active", 64'(ifc.active), 64'h1);
    repeat (3) @(posedge sys_clk);
    #1;
    check("t1_start_latency", 64'(ifc.tx_start), 64'h1);
    check("t1_start_data", 64'(ifc.tx_data), 64'h11);
    wait_wc(16'd1, "t1_word_cnt");
    for (int k = 0; k < 8; k++)
      check($sformatf("t1_byte%0d", k), 64'(cap[base + k]), 64'(8'h11 * 8'(k + 1)));
    check("t1_pops", 64'(pop_cnt - p0), 64'h1);
    check("t1_starts", 64'(start_cnt - s0), 64'h8);
    repeat (3) @(posedge sys_clk);
    #1;
    check("t1_idle", 64'(ifc.active), 64'h0);

    // T3: two queued words back to back
    base = cap_n; p0 = pop_cnt;
    push(64'h8877665544332211);
    push(64'hFFEEDDCCBBAA9988);
    wait_wc(16'd3, "t3_word_cnt");
    for (int k = 0; k < 8; k++)
      check($sformatf("t3_w0_byte%0d", k), 64'(cap[base + k]), 64'(8'h11 * 8'(k + 1)));
    for (int k = 0; k < 8; k++)
      check($sformatf("t3_w1_byte%0d", k), 64'(cap[base + 8 + k]), 64'(8'h88 + 8'h11 * 8'(k)));
    check("t3_pops", 64'(pop_cnt - p0), 64'h2);
    check("t3_second_pop_gap", 64'(last_gap), 64'h1);

    // T4: transmitter busy while the first byte waits in READY
    s0 = start_cnt;
    push(64'h8877665544332211);
    begin
      int n = 0;
      @(posedge sys_clk); #1;
      while (ifc.pop !== 1'b1 && n < 100) begin
        @(posedge sys_clk); #1;
        n++;
      end
      check("t4_pop_seen", 64'(ifc.pop), 64'h1);
    end
    @(negedge sys_clk) hold_busy = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    check("t4_no_start", 64'(start_cnt - s0), 64'h0);
    check("t4_tx_start_low", 64'(ifc.tx_start), 64'h0);
    check("t4_data_ready", 64'(ifc.tx_data), 64'h11);
    check("t4_active", 64'(ifc.active), 64'h1);
    @(negedge sys_clk) hold_busy = 1'b0;
    @(posedge sys_clk); #1;
    check("t4_start_after_release", 64'(ifc.tx_start), 64'h1);
    wait_wc(16'd4, "t4_word_cnt");

    // T5: reset after the third byte starts
    s0 = start_cnt;
    push(64'h8877665544332211);
    begin
      int n = 0;
      while (start_cnt != s0 + 3 && n < 1000) begin
        @(posedge sys_clk); #1;
        n++;
      end
      check("t5_three_starts", 64'(start_cnt - s0), 64'h3);
    end
    @(negedge sys_clk) sys_rst_l = 1'b0;
    @(posedge sys_clk); #1;
    check("t5_pop", 64'(ifc.pop), 64'h0);
    check("t5_tx_start", 64'(ifc.tx_start), 64'h0);
    check("t5_active", 64'(ifc.active), 64'h0);
    check("t5_tx_data", 64'(ifc.tx_data), 64'h0);
    check("t5_word_cnt", 64'(ifc.word_cnt), 64'h0);
    @(negedge sys_clk) sys_rst_l = 1'b1;
    base = cap_n; p0 = pop_cnt;
    push(64'h8877665544332211);
    wait_wc(16'd1, "t5_restart_word_cnt");
    check("t5_restart_byte0", 64'(cap[base]), 64'h11);
    check("t5_restart_byte7", 64'(cap[base + 7]), 64'h88);
    check("t5_restart_pops", 64'(pop_cnt - p0), 64'h1);
    check("t5_restart_bytes", 64'(cap_n - base), 64'h8);

    // T6: word counter wraps
    @(negedge sys_clk) force dut.word_cnt_q = 16'hFFFF;
    @(negedge sys_clk) release dut.word_cnt_q;
    @(posedge sys_clk); #1;
    check("t6_preload", 64'(ifc.word_cnt), 64'hFFFF);
    push(64'h8877665544332211);
    wait_wc(16'h0000, "t6_wrap");

    check("no_start_while_busy", 64'(viol), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
